// File: rtl/csr_pkg.sv
// Shared machine-mode CSR definitions: addresses, trap cause codes, status/enable
// bit positions and the CSR read-modify-write operation encoding.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    localparam logic [3:0] IRQ_MSI      = 4'd3;
    localparam logic [3:0] IRQ_MTI      = 4'd7;
    localparam logic [3:0] IRQ_MEI      = 4'd11;
    localparam logic [3:0] EXC_ILLEGAL  = 4'd2;
    localparam logic [3:0] EXC_BREAK    = 4'd3;
    localparam logic [3:0] EXC_ECALL_M  = 4'd11;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MSIE     = 3;
    localparam int MIE_MTIE     = 7;
    localparam int MIE_MEIE     = 11;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    // Read-modify-write merge; callers truncate to their datapath width.
    function automatic logic [63:0] csr_apply(input csr_op_e op, input logic [63:0] old,
                                              input logic [63:0] src);
        case (op)
            CSR_OP_RW: csr_apply = src;
            CSR_OP_RS: csr_apply = old | src;
            CSR_OP_RC: csr_apply = old & ~src;
            default:   csr_apply = old;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent half loads; any load in a cycle
// takes precedence over (and suppresses) that cycle's increment.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        load_lo,
    input  logic        load_hi,
    input  logic [31:0] lo_val,
    input  logic [31:0] hi_val,
    output logic [63:0] count
);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load_lo || load_hi) begin
            if (load_lo) count[31:0]  <= lo_val;
            if (load_hi) count[63:32] <= hi_val;
        end else if (inc) begin
            count <= count + 64'd1;
        end
    end

endmodule

// File: rtl/csr_file_trap.sv
// Machine-mode CSR file with trap/mret sequencing at writeback: resolves interrupt,
// exception, mret and CSR write for the retiring instruction and drives fetch redirect.
module csr_file_trap
    import csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [31:0]     VENDOR_ID   = 32'h79737978,
    parameter logic [31:0]     ARCH_ID     = 32'd24100030,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_wbu,
    input  logic [XLEN-1:0] pc_wbu,
    input  logic            csr_we,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_waddr,
    input  logic [XLEN-1:0] csr_wsrc,
    input  logic            exc_valid,
    input  logic [3:0]      exc_cause,
    input  logic            mret_wbu,
    input  logic            irq_ext,
    input  logic            irq_timer,
    input  logic            irq_soft,
    input  logic [11:0]     csr_raddr,
    output logic [XLEN-1:0] csr_rdata,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            irq_pending
);

    localparam bit IS64 = (XLEN == 64);

    logic            mstatus_mie, mstatus_mpie;
    logic [2:0]      mie_q, mip_q;        // {external, timer, software}
    logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
    logic [63:0]     mcycle, minstret;

    logic            take_irq, take_exc, trap, take_mret, do_write;
    logic [3:0]      irq_code;
    logic [XLEN-1:0] old_val, wval, cause_val, tvec_base, trap_pc;
    logic [63:0]     wval64;
    logic [31:0]     hi_val;

    function automatic logic [XLEN-1:0] read_csr(input logic [11:0] addr);
        logic [XLEN-1:0] r;
        r = '0;
        case (addr)
            CSR_MSTATUS: begin
                r[12:11]          = 2'b11;
                r[MSTATUS_MPIE]   = mstatus_mpie;
                r[MSTATUS_MIE]    = mstatus_mie;
            end
            CSR_MIE: begin
                r[MIE_MEIE] = mie_q[2];
                r[MIE_MTIE] = mie_q[1];
                r[MIE_MSIE] = mie_q[0];
            end
            CSR_MIP: begin
                r[MIE_MEIE] = mip_q[2];
                r[MIE_MTIE] = mip_q[1];
                r[MIE_MSIE] = mip_q[0];
            end
            CSR_MTVEC:     r = mtvec_q;
            CSR_MSCRATCH:  r = mscratch_q;
            CSR_MEPC:      r = mepc_q;
            CSR_MCAUSE:    r = mcause_q;
            CSR_MCYCLE:    r = XLEN'(mcycle);
            CSR_MINSTRET:  r = XLEN'(minstret);
            CSR_MCYCLEH:   r = IS64 ? '0 : XLEN'(mcycle[63:32]);
            CSR_MINSTRETH: r = IS64 ? '0 : XLEN'(minstret[63:32]);
            CSR_MVENDORID: r = XLEN'(VENDOR_ID);
            CSR_MARCHID:   r = XLEN'(ARCH_ID);
            default:       r = '0;
        endcase
        return r;
    endfunction

    assign csr_rdata   = read_csr(csr_raddr);
    assign irq_pending = mstatus_mie & |(mie_q & mip_q);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        irq_code = IRQ_MTI;
        if (mie_q[2] && mip_q[2])      irq_code = IRQ_MEI;
        else if (mie_q[0] && mip_q[0]) irq_code = IRQ_MSI;

        take_irq  = valid_wbu & irq_pending;
        take_exc  = valid_wbu & exc_valid & ~take_irq;
        trap      = take_irq | take_exc;
        take_mret = valid_wbu & mret_wbu & ~trap;
        do_write  = valid_wbu & csr_we & (csr_op != CSR_OP_NONE) & ~trap & ~take_mret;

        old_val   = read_csr(csr_waddr);
        wval      = XLEN'(csr_apply(csr_op_e'(csr_op), 64'(old_val), 64'(csr_wsrc)));
        wval64    = 64'(wval);
        hi_val    = IS64 ? wval64[63:32] : wval64[31:0];

        cause_val = take_irq ? {1'b1, {(XLEN-5){1'b0}}, irq_code} : XLEN'(exc_cause);
        tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
        trap_pc   = (take_irq && mtvec_q[0]) ? tvec_base + XLEN'({irq_code, 2'b00}) : tvec_base;

        // Gated by rst_n so a stray valid_wbu cannot redirect fetch while in reset.
        redirect_valid = rst_n & (trap | take_mret);
        redirect_pc    = take_mret ? mepc_q : trap_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_q        <= '0;
            mip_q        <= '0;
            mtvec_q      <= RESET_MTVEC & ~XLEN'(2);
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
        end else begin
            mip_q <= {irq_ext, irq_timer, irq_soft};
            if (trap) begin
                mepc_q       <= pc_wbu & ~XLEN'(3);
                mcause_q     <= cause_val;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (take_mret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else if (do_write) begin
                case (csr_waddr)
                    CSR_MSTATUS: begin
                        mstatus_mie  <= wval[MSTATUS_MIE];
                        mstatus_mpie <= wval[MSTATUS_MPIE];
                    end
                    CSR_MIE:      mie_q      <= {wval[MIE_MEIE], wval[MIE_MTIE], wval[MIE_MSIE]};
                    CSR_MTVEC:    mtvec_q    <= wval & ~XLEN'(2);
                    CSR_MSCRATCH: mscratch_q <= wval;
                    CSR_MEPC:     mepc_q     <= wval & ~XLEN'(3);
                    CSR_MCAUSE:   mcause_q   <= wval;
                    default: ;
                endcase
            end
        end
    end

    // At XLEN=64 the low address covers the full counter, so it loads both halves.
    csr_counter64 u_mcycle (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (1'b1),
        .load_lo (do_write && csr_waddr == CSR_MCYCLE),
        .load_hi (do_write && csr_waddr == (IS64 ? CSR_MCYCLE : CSR_MCYCLEH)),
        .lo_val  (wval64[31:0]),
        .hi_val  (hi_val),
        .count   (mcycle)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (valid_wbu & ~trap),
        .load_lo (do_write && csr_waddr == CSR_MINSTRET),
        .load_hi (do_write && csr_waddr == (IS64 ? CSR_MINSTRET : CSR_MINSTRETH)),
        .lo_val  (wval64[31:0]),
        .hi_val  (hi_val),
        .count   (minstret)
    );

endmodule

// File: tb/tb_csr_file_trap.sv
// Scoreboard bench for csr_file_trap (XLEN=32): stimulus queues expected reads and
// redirects, a negedge monitor pops and compares whenever the DUT presents them.
module tb_csr_file_trap;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_wbu, csr_we, exc_valid, mret_wbu;
    logic [31:0] pc_wbu, csr_wsrc, csr_rdata, redirect_pc;
    logic [1:0]  csr_op;
    logic [11:0] csr_waddr, csr_raddr;
    logic [3:0]  exc_cause;
    logic        irq_ext, irq_timer, irq_soft;
    logic        redirect_valid, irq_pending;

    always #5 clk = ~clk;

    csr_file_trap dut (
        .clk(clk), .rst_n(rst_n), .valid_wbu(valid_wbu), .pc_wbu(pc_wbu),
        .csr_we(csr_we), .csr_op(csr_op), .csr_waddr(csr_waddr), .csr_wsrc(csr_wsrc),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .mret_wbu(mret_wbu),
        .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .irq_pending(irq_pending)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t rd_q[$];
    exp_t rdr_q[$];
    logic rd_req = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n_ret  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rd_req) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL read_unexpected: got %h expected no read", csr_rdata);
            end else begin
                e = rd_q.pop_front();
                check(e.name, csr_rdata, e.val);
            end
        end
        if (redirect_valid === 1'b1) begin
            if (rdr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL redirect_unexpected: got pc %h expected no redirect", redirect_pc);
            end else begin
                e = rdr_q.pop_front();
                check(e.name, redirect_pc, e.val);
            end
        end
    end

    task automatic clear_inputs();
        valid_wbu = 1'b0; pc_wbu = '0; csr_we = 1'b0; csr_op = 2'b00;
        csr_waddr = '0; csr_wsrc = '0; exc_valid = 1'b0; exc_cause = '0; mret_wbu = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] v, input string name);
        rd_q.push_back('{name, v});
        csr_raddr = a;
        rd_req    = 1'b1;
        step();
        rd_req    = 1'b0;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [1:0] op, input logic [11:0] addr,
                          input logic [31:0] src, input logic exc, input logic [3:0] cause,
                          input logic mret, input logic redir, input logic [31:0] rpc,
                          input logic is_trap, input string name);
        if (redir) rdr_q.push_back('{name, rpc});
        if (!is_trap) n_ret++;
        valid_wbu = 1'b1; pc_wbu = pc; csr_we = 1'b1; csr_op = op; csr_waddr = addr;
        csr_wsrc = src; exc_valid = exc; exc_cause = cause; mret_wbu = mret;
        step();
        clear_inputs();
    endtask

    task automatic csr_write(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] src);
        retire(32'h1000, op, addr, src, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0, 1'b0, "");
    endtask

    initial begin
        clear_inputs();
        csr_raddr = '0;
        irq_ext = 1'b0; irq_timer = 1'b0; irq_soft = 1'b0;
        rst_n = 1'b0;
        // Retire-like activity during reset must not redirect or count.
        valid_wbu = 1'b1; mret_wbu = 1'b1; exc_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        check("rst_irq_pending", 32'(irq_pending), 32'd0);
        @(posedge clk); #1;
        clear_inputs();
        rst_n = 1'b1;

        rd(CSR_MSTATUS,   32'h0000_1800, "mstatus_reset");
        rd(CSR_MTVEC,     32'h0,         "mtvec_reset");
        rd(CSR_MIE,       32'h0,         "mie_reset");
        rd(CSR_MCAUSE,    32'h0,         "mcause_reset");
        rd(CSR_MVENDORID, 32'h7973_7978, "mvendorid");
        rd(CSR_MARCHID,   32'd24100030,  "marchid");

        csr_write(CSR_OP_RS, CSR_MSTATUS, 32'h8);
        rd(CSR_MSTATUS, 32'h0000_1808, "mstatus_rs_mie");
        csr_write(CSR_OP_RC, CSR_MSTATUS, 32'h8);
        rd(CSR_MSTATUS, 32'h0000_1800, "mstatus_rc_mie");
        csr_write(CSR_OP_RW, CSR_MSTATUS, 32'hFFFF_FFFF);
        rd(CSR_MSTATUS, 32'h0000_1888, "mstatus_rw_mask");
        csr_write(CSR_OP_RW, CSR_MSTATUS, 32'h0);

        csr_write(CSR_OP_RW, CSR_MSCRATCH, 32'hDEAD_BEEF);
        rd(CSR_MSCRATCH, 32'hDEAD_BEEF, "mscratch_rw");
        csr_write(CSR_OP_RS, CSR_MSCRATCH, 32'h10);
        rd(CSR_MSCRATCH, 32'hDEAD_BEFF, "mscratch_rs");
        csr_write(CSR_OP_RC, CSR_MSCRATCH, 32'hF);
        rd(CSR_MSCRATCH, 32'hDEAD_BEF0, "mscratch_rc");
        csr_write(CSR_OP_NONE, CSR_MSCRATCH, 32'h0);
        rd(CSR_MSCRATCH, 32'hDEAD_BEF0, "mscratch_op_none");

        csr_write(CSR_OP_RW, CSR_MIE, 32'hFFFF_FFFF);
        rd(CSR_MIE, 32'h0000_0888, "mie_mask");
        csr_write(CSR_OP_RW, 12'h7C0, 32'hFFFF_FFFF);
        rd(12'h7C0, 32'h0, "unmapped_reads_zero");
        csr_write(CSR_OP_RW, CSR_MIP, 32'hFFFF_FFFF);
        rd(CSR_MIP, 32'h0, "mip_readonly");
        csr_write(CSR_OP_RW, CSR_MVENDORID, 32'h0);
        rd(CSR_MVENDORID, 32'h7973_7978, "mvendorid_readonly");
        csr_write(CSR_OP_RW, CSR_MTVEC, 32'h8000_0003);
        rd(CSR_MTVEC, 32'h8000_0001, "mtvec_bit1_zero");
        csr_write(CSR_OP_RW, CSR_MEPC, 32'h0000_0207);
        rd(CSR_MEPC, 32'h0000_0204, "mepc_low_zero");

        // Timer interrupt, vectored; exception and CSR write in the same cycle lose.
        csr_write(CSR_OP_RW, CSR_MIE, 32'h80);
        irq_timer = 1'b1;
        step();
        rd(CSR_MIP, 32'h0000_0080, "mip_timer");
        csr_write(CSR_OP_RS, CSR_MSTATUS, 32'h8);
        @(negedge clk);
        check("irq_pending_timer", 32'(irq_pending), 32'd1);
        @(posedge clk); #1;
        retire(32'h100, CSR_OP_RW, CSR_MSCRATCH, 32'h1111_1111, 1'b1, EXC_ILLEGAL, 1'b0,
               1'b1, 32'h8000_001C, 1'b1, "redirect_mti_vectored");
        irq_timer = 1'b0;
        rd(CSR_MCAUSE,   32'h8000_0007, "mcause_mti");
        rd(CSR_MEPC,     32'h0000_0100, "mepc_mti");
        rd(CSR_MSTATUS,  32'h0000_1880, "mstatus_after_irq");
        rd(CSR_MSCRATCH, 32'hDEAD_BEF0, "mscratch_kept_irq");

        // ecall with a same-cycle CSR write: write discarded, not retired.
        rd(CSR_MINSTRET, n_ret, "minstret_before_ecall");
        retire(32'h200, CSR_OP_RW, CSR_MSCRATCH, 32'h1234_5678, 1'b1, EXC_ECALL_M, 1'b0,
               1'b1, 32'h8000_0000, 1'b1, "redirect_ecall");
        rd(CSR_MCAUSE,   32'd11,        "mcause_ecall");
        rd(CSR_MEPC,     32'h200,       "mepc_ecall");
        rd(CSR_MSCRATCH, 32'hDEAD_BEF0, "mscratch_kept_exc");
        rd(CSR_MINSTRET, n_ret,         "minstret_after_ecall");
        rd(CSR_MSTATUS,  32'h0000_1800, "mstatus_after_exc");

        // mret restores MIE from MPIE and wins over a same-cycle CSR write.
        csr_write(CSR_OP_RW, CSR_MSTATUS, 32'h80);
        csr_write(CSR_OP_RW, CSR_MEPC, 32'h204);
        retire(32'h300, CSR_OP_RW, CSR_MSCRATCH, 32'h0, 1'b0, 4'd0, 1'b1,
               1'b1, 32'h204, 1'b0, "redirect_mret");
        rd(CSR_MSTATUS,  32'h0000_1888, "mstatus_after_mret");
        rd(CSR_MSCRATCH, 32'hDEAD_BEF0, "mscratch_kept_mret");
        rd(CSR_MINSTRET, n_ret,         "minstret_after_mret");

        // MEI beats MSI; then MSI alone.
        csr_write(CSR_OP_RW, CSR_MIE, 32'h888);
        irq_ext = 1'b1; irq_soft = 1'b1;
        step();
        retire(32'h400, CSR_OP_NONE, 12'h0, 32'h0, 1'b0, 4'd0, 1'b0,
               1'b1, 32'h8000_002C, 1'b1, "redirect_mei");
        rd(CSR_MCAUSE, 32'h8000_000B, "mcause_mei");
        irq_ext = 1'b0;
        step();
        csr_write(CSR_OP_RS, CSR_MSTATUS, 32'h8);
        retire(32'h404, CSR_OP_NONE, 12'h0, 32'h0, 1'b0, 4'd0, 1'b0,
               1'b1, 32'h8000_000C, 1'b1, "redirect_msi");
        rd(CSR_MCAUSE, 32'h8000_0003, "mcause_msi");
        rd(CSR_MEPC,   32'h404,       "mepc_msi");
        irq_soft = 1'b0;
        step();

        // Direct mode exception, and no action at all without valid_wbu.
        csr_write(CSR_OP_RW, CSR_MTVEC, 32'h100);
        retire(32'h500, CSR_OP_NONE, 12'h0, 32'h0, 1'b1, EXC_BREAK, 1'b0,
               1'b1, 32'h100, 1'b1, "redirect_ebreak_direct");
        rd(CSR_MCAUSE, 32'd3, "mcause_ebreak");
        exc_valid = 1'b1; mret_wbu = 1'b1; csr_we = 1'b1; csr_op = CSR_OP_RW;
        csr_waddr = CSR_MSCRATCH; csr_wsrc = 32'h0;
        step();
        clear_inputs();
        rd(CSR_MSCRATCH, 32'hDEAD_BEF0, "no_write_without_valid");
        rd(CSR_MCAUSE,   32'd3,         "no_trap_without_valid");

        // Counter half loads and carry into the high half.
        csr_write(CSR_OP_RW, CSR_MCYCLEH, 32'd5);
        csr_write(CSR_OP_RW, CSR_MCYCLE, 32'hFFFF_FFFF);
        rd(CSR_MCYCLE,  32'hFFFF_FFFF, "mcycle_loaded");
        rd(CSR_MCYCLE,  32'h0,         "mcycle_wrapped");
        rd(CSR_MCYCLEH, 32'd6,         "mcycleh_carry");
        csr_write(CSR_OP_RW, CSR_MINSTRET, 32'h10);
        rd(CSR_MINSTRET,  32'h10, "minstret_load_no_inc");
        rd(CSR_MINSTRETH, 32'h0,  "minstreth");

        // Asynchronous reset mid-cycle clears state without waiting for a clock.
        #2;
        rst_n = 1'b0;
        #1; csr_raddr = CSR_MCYCLE;
        #1; check("async_rst_mcycle", csr_rdata, 32'h0);
        csr_raddr = CSR_MCYCLEH;
        #1; check("async_rst_mcycleh", csr_rdata, 32'h0);
        csr_raddr = CSR_MINSTRET;
        #1; check("async_rst_minstret", csr_rdata, 32'h0);
        csr_raddr = CSR_MSTATUS;
        #1; check("async_rst_mstatus", csr_rdata, 32'h0000_1800);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd(CSR_MTVEC, 32'h0, "mtvec_after_rst");
        step();

        check("pending_reads_left", 32'(rd_q.size()), 32'd0);
        check("pending_redirects_left", 32'(rdr_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_file_trap.md
CSR_FILE_TRAP -- requirements
Module: csr_file_trap

Interface
REQ-001 SHALL take parameter XLEN, default 32, meaning datapath/CSR width (32 or 64 only).
REQ-002 SHALL take parameter VENDOR_ID, default 32'h79737978, meaning mvendorid read value.
REQ-003 SHALL take parameter ARCH_ID, default 32'd24100030, meaning marchid read value.
REQ-004 SHALL take parameter RESET_MTVEC, default 0, meaning mtvec reset value.
REQ-005 SHALL have ports, one per line:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_wbu  in  1  instruction retiring this cycle
- pc_wbu  in  XLEN  PC of retiring instruction
- csr_we  in  1  retiring instruction is a CSR instruction that writes
- csr_op  in  2  01 RW, 10 RS (set), 11 RC (clear), 00 no write
- csr_waddr  in  12  write address
- csr_wsrc  in  XLEN  rs1/zimm operand
- exc_valid  in  1  retiring instruction raised a synchronous exception
- exc_cause  in  4  exception code (e.g. 11 ecall, 3 ebreak, 2 illegal)
- mret_wbu  in  1  retiring instruction is mret
- irq_ext, irq_timer, irq_soft  in  1 each  level interrupt requests
- csr_raddr  in  12  read address (decode stage)
- csr_rdata  out  XLEN  combinational read data
- redirect_valid  out  1  fetch redirect this cycle
- redirect_pc  out  XLEN  redirect target
- irq_pending  out  1  an enabled interrupt is pending and globally enabled

Function
REQ-006 SHALL implement mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstret h 0xB82, mvendorid 0xF11, marchid 0xF12; other addresses read 0 and ignore writes.
REQ-007 SHALL compute write value from the current register: RW -> wsrc; RS -> old|wsrc; RC -> old&~wsrc; commit at the edge ending the valid_wbu cycle.
REQ-008 SHALL make mstatus writable only in MIE(3) and MPIE(7); MPP(12:11) SHALL read 2'b11; other bits read 0.
REQ-009 SHALL make mie writable only in bits 11, 7, 3; mip SHALL be read-only, bits 11/7/3 = irq_ext/irq_timer/irq_soft registered one cycle.
REQ-010 SHALL hardwire mtvec bit 1 to 0 (MODE 0 direct, 1 vectored); mepc bits 1:0 SHALL read 0.
REQ-011 SHALL hold mcycle and minstret as 64-bit counters; mcycle +1 every cycle; minstret +1 when valid_wbu and no trap taken; both wrap 2^64-1 -> 0.
REQ-012 SHALL, for XLEN=32, map low/high halves to 0xB00/0xB80, 0xB02/0xB82; for XLEN=64, 0xB00/0xB02 full width and h addresses read 0 and ignore writes.
REQ-013 SHALL, on a CSR write to a counter half, load that half, keep the other half, and suppress that counter's increment that cycle.
REQ-014 SHALL drive irq_pending = mstatus.MIE & |(mie & mip).
REQ-015 SHALL resolve per valid_wbu cycle with priority: interrupt > exception > mret > CSR write; lower-priority effects in that cycle SHALL be discarded.
REQ-016 SHALL select interrupt cause MEI(11) > MSI(3) > MTI(7); mcause = {1, cause}; exception mcause = {0, exc_cause}.
REQ-017 SHALL on trap: mepc<=pc_wbu, mcause set, MPIE<=MIE, MIE<=0, instruction not retired, redirect_valid=1.
REQ-018 SHALL set trap target = mtvec base (bits XLEN-1:2, low bits 0) for exceptions or direct mode; base + 4*cause for interrupts in vectored mode.
REQ-019 SHALL on mret: MIE<=MPIE, MPIE<=1, redirect_valid=1, redirect_pc = current mepc.
REQ-020 SHALL drive redirect_valid/redirect_pc combinationally in the same valid_wbu cycle; redirect_valid=0 when valid_wbu=0.
REQ-021 SHALL take no trap, write, or retire-count action when valid_wbu=0.
REQ-022 SHALL return csr_rdata combinationally from csr_raddr, showing pre-edge state (no write-to-read bypass).

Reset
REQ-023 SHALL asynchronously on rst_n=0 set mstatus=0x1800, mie=0, mip=0, mtvec=RESET_MTVEC, mscratch=0, mepc=0, mcause=0, counters=0.
REQ-024 SHALL hold outputs at redirect_valid=0, irq_pending=0 during reset; release is synchronous to the first clk edge with rst_n=1.

Structure
REQ-025 SHALL place CSR address constants, cause codes, mstatus/mie bit positions and csr_op encoding in shared package csr_pkg.
REQ-026 SHALL instantiate sub-module csr_counter64 (increment, suppress, half-load) twice, for mcycle and minstret.

Verification
REQ-027 RS to mstatus wsrc=0x8 then read 0x300 -> 0x1808; RC 0x8 -> 0x1800.
REQ-028 mtvec=0x80000001, mie=0x80, MIE=1, irq_timer=1, valid_wbu, pc=0x100 -> redirect_pc=0x8000001C, mcause=0x80000007, mepc=0x100, MIE=0, MPIE=1.
REQ-029 exc_valid, cause 11, pc=0x200, with csr_we to mscratch same cycle -> mcause=11, mepc=0x200, mscratch unchanged, minstret unchanged.
REQ-030 mret with mepc=0x204, MPIE=1 -> redirect_pc=0x204, MIE=1, MPIE=1.
REQ-031 XLEN=32, write mcycle=0xFFFFFFFF -> next cycle 0, mcycleh +1; rst_n pulled low mid-run -> all counters 0 immediately.
